// File: rtl/jvm_microseq.sv
// Microcode sequencer: walks a JVM opcode's microinstruction chain through the
// next-address ROM and hands each address to the emit stage under valid/ready.
module jvm_microseq #(
    parameter int ADR_W     = 9,
    parameter int OP_W      = 8,
    parameter int MAX_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bc_valid,
    input  logic [OP_W-1:0]  bc_opcode,
    output logic             bc_ready,
    output logic [ADR_W-1:0] rom_adr,
    input  logic [ADR_W-1:0] rom_next,
    output logic             uop_valid,
    output logic [ADR_W-1:0] uop_adr,
    input  logic             uop_ready,
    input  logic             flush,
    input  logic             clr_err,
    output logic             busy,
    output logic             err,
    output logic [4:0]       step_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Addresses below RUN_BASE are the dispatch region; all-ones marks an unmapped entry.
    localparam logic [ADR_W-1:0] ADR_UNMAPPED = '1;
    localparam logic [ADR_W-1:0] RUN_BASE     = ADR_W'(1 << OP_W);
    localparam logic [4:0]       STEP_LIMIT   = 5'(MAX_STEPS);

    state_t           state_reg, state_next;
    logic [ADR_W-1:0] cur_adr_reg, cur_adr_next;
    logic [4:0]       step_cnt_reg, step_cnt_next;

    logic next_done;
    logic next_legal;

    assign next_done  = (rom_next == '0);
    assign next_legal = (rom_next >= RUN_BASE) && (rom_next != ADR_UNMAPPED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cur_adr_reg  <= '0;
            step_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cur_adr_reg  <= cur_adr_next;
            step_cnt_reg <= step_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_adr_next  = cur_adr_reg;
        step_cnt_next = step_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bc_valid) begin
                    cur_adr_next  = {{(ADR_W-OP_W){1'b0}}, bc_opcode};
                    step_cnt_next = 5'd1;
                    state_next    = RUN;
                end
            end
            RUN: begin
                // Flush wins over a simultaneous consume: the presented address is dropped.
                if (flush) begin
                    state_next = IDLE;
                end else if (uop_ready) begin
                    if (next_done) begin
                        state_next = IDLE;
                    end else if (next_legal) begin
                        if (step_cnt_reg == STEP_LIMIT) begin
                            state_next = ERR;
                        end else begin
                            cur_adr_next  = rom_next;
                            step_cnt_next = step_cnt_reg + 5'd1;
                        end
                    end else begin
                        // cur_adr stays on the offending microinstruction for debug.
                        state_next = ERR;
                    end
                end
            end
            ERR: begin
                if (clr_err) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bc_ready  = (state_reg == IDLE);
    assign uop_valid = (state_reg == RUN);
    assign busy      = (state_reg == RUN);
    assign err       = (state_reg == ERR);
    assign rom_adr   = cur_adr_reg;
    assign uop_adr   = cur_adr_reg;
    assign step_cnt  = step_cnt_reg;

endmodule

// File: tb/tb_jvm_microseq.sv
// Directed bench for jvm_microseq with a small next-address ROM model.
module tb_jvm_microseq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bc_valid = 1'b0;
    logic [7:0] bc_opcode = 8'h00;
    logic       bc_ready;
    logic [8:0] rom_adr;
    logic [8:0] rom_next;
    logic       uop_valid;
    logic [8:0] uop_adr;
    logic       uop_ready = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic       busy;
    logic       err;
    logic [4:0] step_cnt;

    int total = 0;
    int bad = 0;
    int n_consumed = 0;

    jvm_microseq #(.ADR_W(9), .OP_W(8), .MAX_STEPS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .bc_valid(bc_valid), .bc_opcode(bc_opcode), .bc_ready(bc_ready),
        .rom_adr(rom_adr), .rom_next(rom_next),
        .uop_valid(uop_valid), .uop_adr(uop_adr), .uop_ready(uop_ready),
        .flush(flush), .clr_err(clr_err),
        .busy(busy), .err(err), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // Next-address ROM model.
    always_comb begin
        case (rom_adr)
            9'h059:  rom_next = 9'h100;
            9'h100:  rom_next = 9'h101;
            9'h101:  rom_next = 9'h000;
            9'h05C:  rom_next = 9'h1FF;
            9'h02A:  rom_next = 9'h12C;
            9'h12C:  rom_next = 9'h12C;
            9'h010:  rom_next = 9'h020;
            default: rom_next = 9'h000;
        endcase
    end

    always @(posedge clk) begin
        if (rst_n && uop_valid && uop_ready && !flush)
            n_consumed <= n_consumed + 1;
    end

    task automatic test_reset();
        #1;
        total++; if (bc_ready !== 1'b1 || uop_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got ready=%b valid=%b busy=%b err=%b, need 1 0 0 0", bc_ready, uop_valid, busy, err);
        end
        total++; if (step_cnt !== 5'd0 || rom_adr !== 9'h000) begin
            bad++; $display("FAIL reset_regs: got step_cnt=%0d rom_adr=%h, need 0 000", step_cnt, rom_adr);
        end
        #12 rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_chain();
        logic [8:0] exp_adr [3] = '{9'h059, 9'h100, 9'h101};
        int c0;
        @(posedge clk); #1;
        c0 = n_consumed; bc_valid = 1'b1; bc_opcode = 8'h59; uop_ready = 1'b1;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (uop_valid !== 1'b1 || uop_adr !== exp_adr[i] || rom_adr !== exp_adr[i]) begin
                bad++; $display("FAIL chain_adr[%0d]: got valid=%b uop=%h rom=%h, need valid=1 adr=%h", i, uop_valid, uop_adr, rom_adr, exp_adr[i]);
            end
            total++; if (step_cnt !== 5'(i + 1) || bc_ready !== 1'b0) begin
                bad++; $display("FAIL chain_cnt[%0d]: got step_cnt=%0d bc_ready=%b, need %0d 0", i, step_cnt, bc_ready, i + 1);
            end
            @(posedge clk); #1;
        end
        total++; if (bc_ready !== 1'b1 || busy !== 1'b0 || uop_valid !== 1'b0) begin
            bad++; $display("FAIL chain_idle: got ready=%b busy=%b valid=%b, need 1 0 0", bc_ready, busy, uop_valid);
        end
        total++; if (n_consumed - c0 !== 3) begin
            bad++; $display("FAIL chain_consumed: got %0d, need 3", n_consumed - c0);
        end
        uop_ready = 1'b0;
        $display("txn opcode=59 chain of 3 done");
    endtask

    task automatic test_backpressure();
        int c0;
        @(posedge clk); #1;
        c0 = n_consumed; bc_valid = 1'b1; bc_opcode = 8'h00; uop_ready = 1'b0;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (uop_valid !== 1'b1 || uop_adr !== 9'h000 || busy !== 1'b1 || step_cnt !== 5'd1) begin
                bad++; $display("FAIL bp_hold[%0d]: got valid=%b adr=%h busy=%b cnt=%0d, need 1 000 1 1", i, uop_valid, uop_adr, busy, step_cnt);
            end
            uop_ready = (i == 3);
            @(posedge clk); #1;
        end
        total++; if (bc_ready !== 1'b1 || uop_valid !== 1'b0 || n_consumed - c0 !== 1) begin
            bad++; $display("FAIL bp_done: got ready=%b valid=%b consumed=%0d, need 1 0 1", bc_ready, uop_valid, n_consumed - c0);
        end
        uop_ready = 1'b0;
        $display("txn opcode=00 with backpressure done");
    endtask

    task automatic test_err_opcode(input logic [7:0] op, input string name);
        int c0;
        @(posedge clk); #1;
        c0 = n_consumed; bc_valid = 1'b1; bc_opcode = op; uop_ready = 1'b1;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        total++; if (uop_valid !== 1'b1 || uop_adr !== {1'b0, op}) begin
            bad++; $display("FAIL %s_issue: got valid=%b adr=%h, need 1 %h", name, uop_valid, uop_adr, {1'b0, op});
        end
        @(posedge clk); #1;
        uop_ready = 1'b0;
        total++; if (err !== 1'b1 || uop_valid !== 1'b0 || bc_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_err: got err=%b valid=%b ready=%b busy=%b, need 1 0 0 0", name, err, uop_valid, bc_ready, busy);
        end
        total++; if (rom_adr !== {1'b0, op} || n_consumed - c0 !== 1) begin
            bad++; $display("FAIL %s_freeze: got rom_adr=%h consumed=%0d, need %h 1", name, rom_adr, n_consumed - c0, {1'b0, op});
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (err !== 1'b1) begin
            bad++; $display("FAIL %s_flush_in_err: got err=%b, need 1", name, err);
        end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        total++; if (err !== 1'b0 || bc_ready !== 1'b1) begin
            bad++; $display("FAIL %s_clr: got err=%b ready=%b, need 0 1", name, err, bc_ready);
        end
        $display("txn opcode=%h %s error handled", op, name);
    endtask

    task automatic test_runaway();
        int c0;
        @(posedge clk); #1;
        c0 = n_consumed; bc_valid = 1'b1; bc_opcode = 8'h2A; uop_ready = 1'b1;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        for (int i = 0; i < 40 && err !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        uop_ready = 1'b0;
        total++; if (err !== 1'b1) begin
            bad++; $display("FAIL runaway_timeout: got err=%b after 40 cycles, need 1", err);
        end
        total++; if (n_consumed - c0 !== 16 || step_cnt !== 5'd16 || rom_adr !== 9'h12C) begin
            bad++; $display("FAIL runaway_count: got consumed=%0d cnt=%0d rom_adr=%h, need 16 16 12C", n_consumed - c0, step_cnt, rom_adr);
        end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        total++; if (err !== 1'b0 || bc_ready !== 1'b1) begin
            bad++; $display("FAIL runaway_clr: got err=%b ready=%b, need 0 1", err, bc_ready);
        end
        $display("txn opcode=2A runaway chain handled");
    endtask

    task automatic test_flush();
        int c0;
        @(posedge clk); #1;
        c0 = n_consumed; bc_valid = 1'b1; bc_opcode = 8'h59; uop_ready = 1'b1;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (uop_valid !== 1'b1 || uop_adr !== 9'h100) begin
            bad++; $display("FAIL flush_pre: got valid=%b adr=%h, need 1 100", uop_valid, uop_adr);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (bc_ready !== 1'b1 || uop_valid !== 1'b0 || n_consumed - c0 !== 1) begin
            bad++; $display("FAIL flush_idle: got ready=%b valid=%b consumed=%0d, need 1 0 1", bc_ready, uop_valid, n_consumed - c0);
        end
        bc_valid = 1'b1; bc_opcode = 8'h00;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        total++; if (uop_valid !== 1'b1 || uop_adr !== 9'h000 || step_cnt !== 5'd1) begin
            bad++; $display("FAIL flush_next_op: got valid=%b adr=%h cnt=%0d, need 1 000 1", uop_valid, uop_adr, step_cnt);
        end
        @(posedge clk); #1;
        uop_ready = 1'b0;
        total++; if (bc_ready !== 1'b1 || n_consumed - c0 !== 2) begin
            bad++; $display("FAIL flush_next_done: got ready=%b consumed=%0d, need 1 2", bc_ready, n_consumed - c0);
        end
        $display("txn opcode=59 flushed, opcode=00 completed");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bc_valid = 1'b1; bc_opcode = 8'h59; uop_ready = 1'b0;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        total++; if (uop_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_run: got valid=%b busy=%b, need 1 1", uop_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (uop_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || bc_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_async: got valid=%b busy=%b err=%b ready=%b, need 0 0 0 1", uop_valid, busy, err, bc_ready);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bc_ready !== 1'b1 || step_cnt !== 5'd0 || uop_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_after: got ready=%b cnt=%0d valid=%b, need 1 0 0", bc_ready, step_cnt, uop_valid);
        end
        $display("txn opcode=59 dropped by reset");
    endtask

    initial begin
        test_reset();
        test_chain();
        test_backpressure();
        test_err_opcode(8'h5C, "unmapped");
        test_err_opcode(8'h10, "dispatch_jump");
        test_runaway();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
